// File: rtl/fault_counters.sv
// CAN fault-confinement error counters: REC, TEC and the bus-off recovery counter ERB,
// with combinational threshold flags taken straight from the count registers.
module fault_counters #(
    parameter int REC_RELOAD    = 120,
    parameter int RECOVERY_BITS = 11,
    parameter int RECOVERY_SEQS = 128
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       resetcount,
    input  logic       busoff,
    input  logic       sample,
    input  logic       rx_bit,
    input  logic       rec_inc1,
    input  logic       rec_inc8,
    input  logic       rec_dec,
    input  logic       tec_inc8,
    input  logic       tec_dec,
    output logic [7:0] rec,
    output logic [8:0] tec,
    output logic [7:0] erb,
    output logic       rec_lt96,
    output logic       rec_ge96,
    output logic       rec_ge128,
    output logic       tec_lt96,
    output logic       tec_ge96,
    output logic       tec_ge128,
    output logic       tec_ge256,
    output logic       erb_eq128
);

    localparam logic [7:0] RELOAD_VAL = 8'(REC_RELOAD);
    localparam logic [3:0] BIT_LAST   = 4'(RECOVERY_BITS - 1);
    localparam logic [7:0] ERB_MAX    = 8'(RECOVERY_SEQS);

    logic [3:0] bitcnt;

    function automatic logic [7:0] rec_sat_add(input logic [7:0] val, input logic [3:0] inc);
        logic [8:0] sum;
        sum = {1'b0, val} + {5'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // TEC tops out at 256 (bus-off threshold), never beyond.
    function automatic logic [8:0] tec_sat_add8(input logic [8:0] val);
        return (val >= 9'd248) ? 9'd256 : val + 9'd8;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset || !resetcount) begin
            rec    <= '0;
            tec    <= '0;
            erb    <= '0;
            bitcnt <= '0;
        end else if (!busoff) begin
            if (rec_inc8)
                rec <= rec_sat_add(rec, 4'd8);
            else if (rec_inc1)
                rec <= rec_sat_add(rec, 4'd1);
            else if (rec_dec) begin
                if (rec > 8'd127)
                    rec <= RELOAD_VAL;
                else if (rec != 8'd0)
                    rec <= rec - 8'd1;
            end

            if (tec_inc8)
                tec <= tec_sat_add8(tec);
            else if (tec_dec && tec != 9'd0)
                tec <= tec - 9'd1;

            // Leaving bus-off (or never being in it) discards any recovery progress.
            bitcnt <= '0;
            erb    <= '0;
        end else if (sample) begin
            if (!rx_bit)
                bitcnt <= '0;
            else if (bitcnt == BIT_LAST) begin
                bitcnt <= '0;
                if (erb != ERB_MAX)
                    erb <= erb + 8'd1;
            end else if (bitcnt > BIT_LAST)
                bitcnt <= 4'd1;
            else
                bitcnt <= bitcnt + 4'd1;
        end
    end

    assign rec_lt96  = (rec < 8'd96);
    assign rec_ge96  = (rec >= 8'd96);
    assign rec_ge128 = (rec >= 8'd128);
    assign tec_lt96  = (tec < 9'd96);
    assign tec_ge96  = (tec >= 9'd96);
    assign tec_ge128 = (tec >= 9'd128);
    assign tec_ge256 = (tec >= 9'd256);
    assign erb_eq128 = (erb == ERB_MAX);

endmodule

// File: tb/tb_fault_counters.sv
// Bench for fault_counters: a vector table plus model-driven sequences, checked through
// an expectation queue one cycle after each stimulus is applied.
module tb_fault_counters;

    logic       clock = 1'b0;
    logic       reset, resetcount, busoff, sample, rx_bit;
    logic       rec_inc1, rec_inc8, rec_dec, tec_inc8, tec_dec;
    logic [7:0] rec;
    logic [8:0] tec;
    logic [7:0] erb;
    logic       rec_lt96, rec_ge96, rec_ge128;
    logic       tec_lt96, tec_ge96, tec_ge128, tec_ge256, erb_eq128;

    fault_counters dut (
        .clock(clock), .reset(reset), .resetcount(resetcount), .busoff(busoff),
        .sample(sample), .rx_bit(rx_bit), .rec_inc1(rec_inc1), .rec_inc8(rec_inc8),
        .rec_dec(rec_dec), .tec_inc8(tec_inc8), .tec_dec(tec_dec),
        .rec(rec), .tec(tec), .erb(erb),
        .rec_lt96(rec_lt96), .rec_ge96(rec_ge96), .rec_ge128(rec_ge128),
        .tec_lt96(tec_lt96), .tec_ge96(tec_ge96), .tec_ge128(tec_ge128),
        .tec_ge256(tec_ge256), .erb_eq128(erb_eq128)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit rst_n, rc_n, bo, smp, rx, ri1, ri8, rd, ti8, td;
    } vec_t;

    typedef struct {
        vec_t in;
        int   rec, tec, erb;
    } row_t;

    typedef struct {
        int    rec, tec, erb;
        string name;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   m_rec = 0, m_tec = 0, m_erb = 0, m_bit = 0;

    function automatic vec_t mk(bit rst_n, bit rc_n, bit bo, bit smp, bit rx,
                                bit ri1, bit ri8, bit rd, bit ti8, bit td);
        vec_t v;
        v.rst_n = rst_n; v.rc_n = rc_n; v.bo = bo; v.smp = smp; v.rx = rx;
        v.ri1 = ri1; v.ri8 = ri8; v.rd = rd; v.ti8 = ti8; v.td = td;
        return v;
    endfunction

    // Reference behaviour of the counters, written from the event rules directly.
    task automatic model_apply(input vec_t v);
        if (!v.rst_n || !v.rc_n) begin
            m_rec = 0; m_tec = 0; m_erb = 0; m_bit = 0;
        end else if (!v.bo) begin
            if (v.ri8)      m_rec = (m_rec + 8 > 255) ? 255 : m_rec + 8;
            else if (v.ri1) m_rec = (m_rec + 1 > 255) ? 255 : m_rec + 1;
            else if (v.rd)  m_rec = (m_rec > 127) ? 120 : (m_rec > 0 ? m_rec - 1 : 0);
            if (v.ti8)      m_tec = (m_tec + 8 > 256) ? 256 : m_tec + 8;
            else if (v.td)  m_tec = (m_tec > 0) ? m_tec - 1 : 0;
            m_bit = 0;
            m_erb = 0;
        end else if (v.smp) begin
            if (!v.rx) m_bit = 0;
            else if (m_bit == 10) begin
                m_bit = 0;
                if (m_erb < 128) m_erb = m_erb + 1;
            end else m_bit = m_bit + 1;
        end
    endtask

    task automatic check(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Drive one cycle, queue the expectation, then compare just after the clock edge.
    task automatic step(input vec_t v, input int er, input int et, input int eb, input string nm);
        exp_t e;
        bit [7:0] fexp, fact;
        @(negedge clock);
        reset = v.rst_n; resetcount = v.rc_n; busoff = v.bo; sample = v.smp; rx_bit = v.rx;
        rec_inc1 = v.ri1; rec_inc8 = v.ri8; rec_dec = v.rd; tec_inc8 = v.ti8; tec_dec = v.td;
        e.rec = er; e.tec = et; e.erb = eb; e.name = nm;
        sbq.push_back(e);
        @(posedge clock);
        #1;
        if (sbq.size() == 0) begin
            tests++; fails++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sbq.pop_front();
            check({e.name, " rec"}, int'(rec), e.rec);
            check({e.name, " tec"}, int'(tec), e.tec);
            check({e.name, " erb"}, int'(erb), e.erb);
            fexp = {e.rec < 96, e.rec >= 96, e.rec >= 128, e.tec < 96,
                    e.tec >= 96, e.tec >= 128, e.tec >= 256, e.erb == 128};
            fact = {rec_lt96, rec_ge96, rec_ge128, tec_lt96,
                    tec_ge96, tec_ge128, tec_ge256, erb_eq128};
            check({e.name, " flags"}, int'(fact), int'(fexp));
        end
    endtask

    task automatic mstep(input vec_t v, input string nm);
        model_apply(v);
        step(v, m_rec, m_tec, m_erb, nm);
    endtask

    row_t tbl[14];

    initial begin
        reset = 1'b0; resetcount = 1'b1; busoff = 1'b0; sample = 1'b0; rx_bit = 1'b1;
        rec_inc1 = 1'b0; rec_inc8 = 1'b0; rec_dec = 1'b0; tec_inc8 = 1'b0; tec_dec = 1'b0;

        // args: rst_n rc_n bo smp rx ri1 ri8 rd ti8 td
        tbl[0]  = '{mk(1,1,0,0,0, 0,0,1, 0,1),  0,  0, 0};
        tbl[1]  = '{mk(1,1,0,0,0, 0,0,0, 1,0),  0,  8, 0};
        tbl[2]  = '{mk(1,1,0,0,0, 0,0,0, 1,1),  0, 16, 0};
        tbl[3]  = '{mk(1,1,0,0,0, 0,0,0, 0,1),  0, 15, 0};
        tbl[4]  = '{mk(1,1,0,0,0, 1,0,0, 0,0),  1, 15, 0};
        tbl[5]  = '{mk(1,1,0,0,0, 1,0,1, 0,0),  2, 15, 0};
        tbl[6]  = '{mk(1,1,0,0,0, 0,0,1, 0,0),  1, 15, 0};
        tbl[7]  = '{mk(1,1,0,0,0, 1,1,1, 0,0),  9, 15, 0};
        tbl[8]  = '{mk(1,1,1,0,0, 0,1,1, 1,1),  9, 15, 0};
        tbl[9]  = '{mk(1,1,1,1,1, 0,0,0, 0,0),  9, 15, 0};
        tbl[10] = '{mk(1,1,0,1,1, 0,0,0, 1,0),  9, 23, 0};
        tbl[11] = '{mk(1,0,0,0,0, 0,1,0, 1,0),  0,  0, 0};
        tbl[12] = '{mk(1,1,0,0,0, 0,1,0, 0,0),  8,  0, 0};
        tbl[13] = '{mk(0,0,0,0,0, 0,1,0, 1,0),  0,  0, 0};

        // Reset held two cycles with random events on the inputs.
        for (int i = 0; i < 2; i++) begin
            mstep(mk(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)),
                  $sformatf("reset%0d", i));
        end

        for (int i = 0; i < 14; i++) begin
            model_apply(tbl[i].in);
            step(tbl[i].in, tbl[i].rec, tbl[i].tec, tbl[i].erb, $sformatf("vec%0d", i));
        end

        // REC ramp across the 96 and 128 thresholds, reload, and inc1+inc8 conflict.
        for (int i = 0; i < 16; i++) mstep(mk(1,1,0,0,0, 0,1,0, 0,0), $sformatf("rec_ramp%0d", i));
        mstep(mk(1,1,0,0,0, 0,0,1, 0,0), "rec_reload");
        mstep(mk(1,1,0,0,0, 1,1,0, 0,0), "rec_inc1_inc8");
        for (int i = 0; i < 2; i++) mstep(mk(1,1,0,0,0, 1,0,0, 0,0), $sformatf("rec_to130_%0d", i));

        // TEC to bus-off level and saturation; busoff freezes it.
        for (int i = 0; i < 34; i++) mstep(mk(1,1,0,0,0, 0,0,0, 1,0), $sformatf("tec_ramp%0d", i));
        mstep(mk(1,1,1,0,0, 1,0,0, 0,1), "busoff_hold");

        // Recovery: an interrupted partial sequence, then 128 full sequences with gaps.
        for (int i = 0; i < 10; i++) mstep(mk(1,1,1,1,1, 0,0,0, 0,0), $sformatf("rcv_part%0d", i));
        mstep(mk(1,1,1,1,0, 0,0,0, 0,0), "rcv_dominant");
        for (int i = 0; i < 128 * 11; ) begin
            bit s;
            s = ($urandom_range(0, 3) != 0);
            mstep(mk(1,1,1,s,1, 0,0,0, 0,0), "rcv_seq");
            if (s) i++;
        end
        for (int i = 0; i < 22; i++) mstep(mk(1,1,1,1,1, 0,0,0, 0,0), $sformatf("rcv_sat%0d", i));

        // resetcount with rec=130, tec=256, erb=128 and a simultaneous tec_inc8.
        mstep(mk(1,0,1,1,1, 0,0,0, 1,0), "resetcount");

        // Partial progress discarded by reset and by dropping busoff.
        for (int i = 0; i < 5; i++) mstep(mk(1,1,1,1,1, 0,0,0, 0,0), "mid_a");
        mstep(mk(0,1,1,1,1, 0,0,0, 0,0), "mid_reset");
        for (int i = 0; i < 11; i++) mstep(mk(1,1,1,1,1, 0,0,0, 0,0), $sformatf("mid_b%0d", i));
        mstep(mk(1,1,0,1,1, 0,0,0, 0,0), "busoff_drop");
        for (int i = 0; i < 6; i++) mstep(mk(1,1,1,1,1, 0,0,0, 0,0), "mid_c");
        mstep(mk(1,1,0,1,1, 0,0,0, 0,0), "busoff_drop2");
        for (int i = 0; i < 11; i++) mstep(mk(1,1,1,1,1, 0,0,0, 0,0), $sformatf("mid_d%0d", i));

        // Saturation at the top of both counters.
        for (int i = 0; i < 33; i++) mstep(mk(1,1,0,0,0, 0,1,0, 0,0), $sformatf("rec_sat%0d", i));
        mstep(mk(1,1,0,0,0, 1,0,0, 0,0), "rec_sat_inc1");
        mstep(mk(1,1,0,0,0, 0,0,1, 0,0), "rec_255_dec");
        for (int i = 0; i < 32; i++) mstep(mk(1,1,0,0,0, 0,0,0, 1,0), "tec_up");
        mstep(mk(1,1,0,0,0, 0,0,0, 0,1), "tec_256_dec");
        mstep(mk(1,1,0,0,0, 0,0,0, 1,0), "tec_255_inc8");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
